// File: rtl/vga_pkg.sv
// Shared pixel-domain definitions: frame-buffer geometry defaults, RGB444 field layout and the
// per-cycle BRAM slot decision used by the arbiter.
package vga_pkg;

  localparam int AW_DEFAULT       = 16;
  localparam int DW_DEFAULT       = 12;
  localparam int WF_DEPTH_DEFAULT = 4;

  localparam int RGB_R_MSB = 11;
  localparam int RGB_R_LSB = 8;
  localparam int RGB_G_MSB = 7;
  localparam int RGB_G_LSB = 4;
  localparam int RGB_B_MSB = 3;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_t;

  // Display reads are real-time and always take the port; posted writes fill idle slots.
  function automatic slot_t pick_slot(input logic disp_req, input logic wf_empty);
    if (disp_req)
      return SLOT_READ;
    else if (!wf_empty)
      return SLOT_WRITE;
    else
      return SLOT_IDLE;
  endfunction

endpackage

// File: rtl/vram_wfifo.sv
// Write-posting FIFO for draw requests: one-cycle push-to-head latency, full blocks pushes.
// Pointers carry an extra wrap bit so full and empty are distinguishable without a counter.
module vram_wfifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] store [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign level    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (level == (PW+1)'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = store[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wptr[PW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, draw writes are posted and retired
// in idle slots. Read data returns a fixed 2 cycles after disp_req; draw sees backpressure only when full.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int DW       = DW_DEFAULT,
  parameter int WF_DEPTH = WF_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      cpu_resetn,
  input  logic                      disp_req,
  input  logic [AW-1:0]             disp_addr,
  output logic                      disp_valid,
  output logic [DW-1:0]             disp_data,
  input  logic                      draw_valid,
  output logic                      draw_ready,
  input  logic [AW-1:0]             draw_addr,
  input  logic [DW-1:0]             draw_data,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic [DW-1:0]             mem_rdata,
  output logic                      wf_empty,
  output logic [$clog2(WF_DEPTH):0] wf_level
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wreq_t;

  wreq_t         push_req;
  wreq_t         head;
  slot_t         slot;
  logic          wf_full;
  logic          push;
  logic          pop;
  logic [1:0]    rd_tag;
  logic [DW-1:0] disp_hold;

  assign push_req   = '{addr: draw_addr, data: draw_data};
  assign draw_ready = ~wf_full;
  assign push       = draw_valid & draw_ready;

  always_comb slot = pick_slot(disp_req, wf_empty);

  assign pop = (slot == SLOT_WRITE);

  vram_wfifo #(
    .W     ($bits(wreq_t)),
    .DEPTH (WF_DEPTH)
  ) u_wfifo (
    .clk      (clk),
    .rst_n    (cpu_resetn),
    .push     (push),
    .push_dat (push_req),
    .pop      (pop),
    .head_dat (head),
    .level    (wf_level),
    .empty    (wf_empty),
    .full     (wf_full)
  );

  // Idle slots keep address/data stable to avoid needless toggling on the BRAM port.
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (slot)
        SLOT_READ: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= disp_addr;
        end
        SLOT_WRITE: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= head.addr;
          mem_wdata <= head.data;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      rd_tag    <= 2'b00;
      disp_hold <= '0;
    end else begin
      rd_tag <= {rd_tag[0], slot == SLOT_READ};
      if (rd_tag[1]) disp_hold <= mem_rdata;
    end
  end

  assign disp_valid = rd_tag[1];
  assign disp_data  = rd_tag[1] ? mem_rdata : disp_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port BRAM preloaded to 0xA00+addr.
module tb_vram_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 12;
  localparam int WFD = 4;

  logic          clk = 1'b0;
  logic          cpu_resetn;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          draw_valid;
  logic          draw_ready;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          wf_empty;
  logic [$clog2(WFD):0] wf_level;

  logic          preload;
  logic [DW-1:0] bram [1 << AW];

  int total  = 0;
  int passed = 0;

  vram_arbiter #(.AW(AW), .DW(DW), .WF_DEPTH(WFD)) dut (
    .clk        (clk),
    .cpu_resetn (cpu_resetn),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .draw_valid (draw_valid),
    .draw_ready (draw_ready),
    .draw_addr  (draw_addr),
    .draw_data  (draw_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .wf_empty   (wf_empty),
    .wf_level   (wf_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < (1 << AW); a++) bram[a] <= 12'hA00 + 12'(a);
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    cpu_resetn = 1'b0;
    preload    = 1'b1;
    disp_req   = 1'b0;
    disp_addr  = '0;
    draw_valid = 1'b0;
    draw_addr  = '0;
    draw_data  = '0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      disp_req   = 1'($urandom);
      disp_addr  = 16'($urandom);
      draw_valid = 1'($urandom);
      draw_addr  = 16'($urandom);
      draw_data  = 12'($urandom);
      step();
      preload = 1'b0;
    end
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);
    chk("rst_wf_empty", 32'(wf_empty), 32'd1);
    chk("rst_wf_level", 32'(wf_level), 32'd0);
    disp_req   = 1'b0;
    draw_valid = 1'b0;
    cpu_resetn = 1'b1;
    step();
    chk("rst_draw_ready", 32'(draw_ready), 32'd1);
    chk("idle_mem_en", 32'(mem_en), 32'd0);

    // Four back-to-back reads at 0x0010..0x0013
    for (int i = 0; i < 8; i++) begin
      chk("rd_valid", 32'(disp_valid), (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
      if (i >= 2 && i <= 5) chk("rd_data", 32'(disp_data), 32'hA10 + 32'(i - 2));
      disp_req  = (i < 4);
      disp_addr = 16'h0010 + 16'(i);
      step();
    end
    chk("rd_data_hold", 32'(disp_data), 32'hA13);

    // Single posted write, then read back
    draw_valid = 1'b1;
    draw_addr  = 16'h0100;
    draw_data  = 12'hFFF;
    #1;
    chk("wr_ready", 32'(draw_ready), 32'd1);
    step();
    draw_valid = 1'b0;
    chk("wr_n1_we", 32'(mem_we), 32'd0);
    chk("wr_n1_level", 32'(wf_level), 32'd1);
    step();
    chk("wr_n2_en", 32'(mem_en), 32'd1);
    chk("wr_n2_we", 32'(mem_we), 32'd1);
    chk("wr_n2_addr", 32'(mem_addr), 32'h0100);
    chk("wr_n2_wdata", 32'(mem_wdata), 32'hFFF);
    step();
    chk("wr_n3_we", 32'(mem_we), 32'd0);
    chk("wr_n3_empty", 32'(wf_empty), 32'd1);
    disp_req  = 1'b1;
    disp_addr = 16'h0100;
    step();
    disp_req = 1'b0;
    step();
    chk("wr_rb_valid", 32'(disp_valid), 32'd1);
    chk("wr_rb_data", 32'(disp_data), 32'hFFF);

    // Display hogs the port; five writes offered, only four fit
    disp_req  = 1'b1;
    disp_addr = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      draw_valid = 1'b1;
      draw_addr  = 16'h0200 + 16'(k);
      draw_data  = 12'h500 + 12'(k);
      #1;
      chk("full_ready", 32'(draw_ready), (k < 4) ? 32'd1 : 32'd0);
      step();
      chk("full_no_we", 32'(mem_we), 32'd0);
    end
    draw_valid = 1'b0;
    chk("full_level", 32'(wf_level), 32'd4);
    chk("full_ready_lo", 32'(draw_ready), 32'd0);
    disp_req = 1'b0;
    step();
    for (int j = 0; j < 4; j++) begin
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'h0200 + 32'(j));
      chk("drain_wdata", 32'(mem_wdata), 32'h500 + 32'(j));
      step();
    end
    chk("drain_done_we", 32'(mem_we), 32'd0);
    chk("drain_empty", 32'(wf_empty), 32'd1);
    chk("drain_ready", 32'(draw_ready), 32'd1);

    // Push and pop in the same cycle at level 2
    disp_req   = 1'b1;
    draw_valid = 1'b1;
    draw_addr  = 16'h0280;
    draw_data  = 12'h111;
    step();
    draw_addr = 16'h0281;
    draw_data = 12'h222;
    step();
    disp_req  = 1'b0;
    draw_addr = 16'h0282;
    draw_data = 12'h333;
    #1;
    chk("sim_level_before", 32'(wf_level), 32'd2);
    chk("sim_ready", 32'(draw_ready), 32'd1);
    step();
    draw_valid = 1'b0;
    chk("sim_level_after", 32'(wf_level), 32'd2);
    step();
    step();
    step();

    // Ten sequential writes walk the pointers around the ring several times
    for (int i = 0; i < 10; i++) begin
      draw_valid = 1'b1;
      draw_addr  = 16'h0300 + 16'(i);
      draw_data  = 12'h700 + 12'(i);
      step();
    end
    draw_valid = 1'b0;
    step();
    step();
    step();
    chk("sim_mem_a", 32'(bram[16'h0280]), 32'h111);
    chk("sim_mem_b", 32'(bram[16'h0281]), 32'h222);
    chk("sim_mem_c", 32'(bram[16'h0282]), 32'h333);
    for (int i = 0; i < 10; i++)
      chk("wrap_mem", 32'(bram[16'h0300 + 16'(i)]), 32'h700 + 32'(i));
    chk("wrap_empty", 32'(wf_empty), 32'd1);
    chk("dropped_5th", 32'(bram[16'h0204]), 32'hC04);

    // Reset pulse with posted writes and a read in flight
    disp_req  = 1'b1;
    disp_addr = 16'h0012;
    for (int k = 0; k < 3; k++) begin
      draw_valid = 1'b1;
      draw_addr  = 16'h0400 + 16'(k);
      draw_data  = 12'h123;
      step();
    end
    chk("mid_level", 32'(wf_level), 32'd3);
    draw_valid = 1'b0;
    disp_req   = 1'b0;
    cpu_resetn = 1'b0;
    #1;
    chk("mid_rst_en", 32'(mem_en), 32'd0);
    chk("mid_rst_valid", 32'(disp_valid), 32'd0);
    chk("mid_rst_level", 32'(wf_level), 32'd0);
    step();
    cpu_resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_we", 32'(mem_we), 32'd0);
      chk("post_rst_valid", 32'(disp_valid), 32'd0);
    end
    chk("post_rst_empty", 32'(wf_empty), 32'd1);
    chk("post_rst_mem0", 32'(bram[16'h0400]), 32'hE00);
    chk("post_rst_mem1", 32'(bram[16'h0401]), 32'hE01);
    chk("post_rst_mem2", 32'(bram[16'h0402]), 32'hE02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
